// File: rtl/enc10b_elink_serializer.sv
// Buffers 8b/10b words in a small FIFO and serializes them MSB-first, 2 bits per clock,
// onto the e-link. When the FIFO is empty, it fills the link with alternating-disparity K28.5 commas.
module enc10b_elink_serializer #(
    parameter int         DEPTH       = 4,
    parameter logic [9:0] IDLE_WORD_N = 10'b0011111010,
    parameter logic [9:0] IDLE_WORD_P = 10'b1100000101
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               data_10b_in,
    input  logic                     data_10b_en,
    output logic [1:0]               edata_2bit,
    output logic                     word_start,
    output logic                     idle_out,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     fifo_ovf
);

    localparam int         AW         = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);
    localparam logic [2:0]  LAST_PHASE = 3'd4;

    logic [9:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [9:0]    sh;
    logic [2:0]    phase;
    logic          cur_idle;
    logic          idle_sel;
    logic          load;
    logic          pop;
    logic          push;

    // The count is sampled before the edge, so a word written on the same edge as a load is never bypassed.
    always_comb begin
        load = (phase == LAST_PHASE);
        pop  = load && (count != '0);
        push = data_10b_en && ((count != FULL_LEVEL) || pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (data_10b_en && !push) begin
                fifo_ovf <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_10b_in;
        end
    end

    // idle_sel is 1 when the next inserted idle must be the RD+ comma.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh       <= IDLE_WORD_N;
            phase    <= 3'd0;
            cur_idle <= 1'b1;
            idle_sel <= 1'b1;
        end else if (!load) begin
            sh    <= {sh[7:0], 2'b00};
            phase <= phase + 3'd1;
        end else begin
            phase <= 3'd0;
            if (count != '0) begin
                sh       <= mem[rd_ptr];
                cur_idle <= 1'b0;
            end else begin
                sh       <= idle_sel ? IDLE_WORD_P : IDLE_WORD_N;
                cur_idle <= 1'b1;
                idle_sel <= ~idle_sel;
            end
        end
    end

    assign edata_2bit = sh[9:8];
    assign word_start = (phase == 3'd0);
    assign idle_out   = cur_idle;
    assign fifo_level = count;

endmodule

// File: tb/tb_enc10b_elink_serializer.sv
// Self-checking bench for enc10b_elink_serializer: vector table, directed corner sequences
// and randomized traffic against a word-level queue model.
module tb_enc10b_elink_serializer;

    localparam int         DEPTH  = 4;
    localparam logic [9:0] IDLE_N = 10'b0011111010;
    localparam logic [9:0] IDLE_P = 10'b1100000101;

    logic       clk;
    logic       rst;
    logic [9:0] data_10b_in;
    logic       data_10b_en;
    logic [1:0] edata_2bit;
    logic       word_start;
    logic       idle_out;
    logic [2:0] fifo_level;
    logic       fifo_ovf;

    enc10b_elink_serializer #(
        .DEPTH(DEPTH),
        .IDLE_WORD_N(IDLE_N),
        .IDLE_WORD_P(IDLE_P)
    ) dut (
        .clk(clk),
        .rst(rst),
        .data_10b_in(data_10b_in),
        .data_10b_en(data_10b_en),
        .edata_2bit(edata_2bit),
        .word_start(word_start),
        .idle_out(idle_out),
        .fifo_level(fifo_level),
        .fifo_ovf(fifo_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // Reference model: the word on the wire, which pair of it is showing, and the queue behind it.
    logic [9:0] m_q[$];
    logic [9:0] m_cur;
    int         m_pos;
    bit         m_cur_idle;
    int         m_idles;
    bit         m_ovf;

    function automatic void modelReset();
        m_q.delete();
        m_cur      = IDLE_N;
        m_pos      = 0;
        m_cur_idle = 1'b1;
        m_idles    = 1;
        m_ovf      = 1'b0;
    endfunction

    function automatic void modelStep(input logic en, input logic [9:0] d);
        if (m_pos == 4) begin
            m_pos = 0;
            if (m_q.size() > 0) begin
                m_cur      = m_q.pop_front();
                m_cur_idle = 1'b0;
            end else begin
                m_cur      = (m_idles % 2 == 1) ? IDLE_P : IDLE_N;
                m_cur_idle = 1'b1;
                m_idles++;
            end
        end else begin
            m_pos++;
        end
        if (en) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeoutFail(input string name);
        tests++;
        fails++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic checkOutput();
        int pair;
        pair = (int'(m_cur) / (4 ** (4 - m_pos))) % 4;
        chk("edata", 16'(edata_2bit), 16'(pair));
        chk("word_start", 16'(word_start), 16'(m_pos == 0));
        chk("idle_out", 16'(idle_out), 16'(m_cur_idle));
        chk("fifo_level", 16'(fifo_level), 16'(m_q.size()));
        chk("fifo_ovf", 16'(fifo_ovf), 16'(m_ovf));
    endtask

    task automatic applyStimulus(input logic en, input logic [9:0] d);
        data_10b_en = en;
        data_10b_in = d;
        @(posedge clk);
        modelStep(en, d);
        #1;
        checkOutput();
    endtask

    // Asynchronous reset with writes offered meanwhile; they must be ignored.
    task automatic doReset();
        rst         = 1'b0;
        data_10b_en = 1'b1;
        data_10b_in = 10'h155;
        modelReset();
        #1;
        checkOutput();
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput();
        end
        rst         = 1'b1;
        data_10b_en = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((m_q.size() != 0 || !m_cur_idle) && n < 60) begin
            applyStimulus(1'b0, 10'h0);
            n++;
        end
        if (n >= 60) timeoutFail("drain");
    endtask

    typedef struct {
        logic       en;
        logic [9:0] data;
        logic [1:0] edata;
        logic       ws;
        logic       idle;
        int         level;
    } vec_t;

    function automatic vec_t mk(input logic en, input logic [9:0] d, input logic [1:0] e,
                                input logic ws, input logic idl, input int lvl);
        vec_t v;
        v.en = en; v.data = d; v.edata = e; v.ws = ws; v.idle = idl; v.level = lvl;
        return v;
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout at %0t", $time);
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        vec_t vecs[20];
        int   n;

        vecs[0]  = mk(0, 10'h000, 2'b11, 0, 1, 0);
        vecs[1]  = mk(0, 10'h000, 2'b11, 0, 1, 0);
        vecs[2]  = mk(0, 10'h000, 2'b10, 0, 1, 0);
        vecs[3]  = mk(0, 10'h000, 2'b10, 0, 1, 0);
        vecs[4]  = mk(0, 10'h000, 2'b11, 1, 1, 0);
        vecs[5]  = mk(0, 10'h000, 2'b00, 0, 1, 0);
        vecs[6]  = mk(0, 10'h000, 2'b00, 0, 1, 0);
        vecs[7]  = mk(0, 10'h000, 2'b01, 0, 1, 0);
        vecs[8]  = mk(0, 10'h000, 2'b01, 0, 1, 0);
        vecs[9]  = mk(0, 10'h000, 2'b00, 1, 1, 0);
        vecs[10] = mk(1, 10'b1101010110, 2'b11, 0, 1, 1);
        vecs[11] = mk(0, 10'h000, 2'b11, 0, 1, 1);
        vecs[12] = mk(0, 10'h000, 2'b10, 0, 1, 1);
        vecs[13] = mk(0, 10'h000, 2'b10, 0, 1, 1);
        vecs[14] = mk(0, 10'h000, 2'b11, 1, 0, 0);
        vecs[15] = mk(0, 10'h000, 2'b01, 0, 0, 0);
        vecs[16] = mk(0, 10'h000, 2'b01, 0, 0, 0);
        vecs[17] = mk(0, 10'h000, 2'b01, 0, 0, 0);
        vecs[18] = mk(0, 10'h000, 2'b10, 0, 0, 0);
        vecs[19] = mk(0, 10'h000, 2'b11, 1, 1, 0);

        rst         = 1'b0;
        data_10b_en = 1'b0;
        data_10b_in = 10'h0;
        @(posedge clk);
        #1;
        doReset();
        chk("reset_edata", 16'(edata_2bit), 16'(2'b00));
        chk("reset_ws", 16'(word_start), 16'd1);

        // Idle sequence after release, then a single write in steady idle.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vecs[i].en, vecs[i].data);
            chk($sformatf("vec%0d_edata", i), 16'(edata_2bit), 16'(vecs[i].edata));
            chk($sformatf("vec%0d_ws", i), 16'(word_start), 16'(vecs[i].ws));
            chk($sformatf("vec%0d_idle", i), 16'(idle_out), 16'(vecs[i].idle));
            chk($sformatf("vec%0d_level", i), 16'(fifo_level), 16'(vecs[i].level));
        end

        // Four back-to-back words must stream out contiguously.
        applyStimulus(1'b1, 10'h2AA);
        applyStimulus(1'b1, 10'h155);
        applyStimulus(1'b1, 10'h3F0);
        applyStimulus(1'b1, 10'h00F);
        waitDrain();
        chk("b2b_no_ovf", 16'(fifo_ovf), 16'd0);

        // Six consecutive writes overflow a 4-deep FIFO.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 10'(10'h101 + i * 37));
        chk("burst_ovf", 16'(fifo_ovf), 16'd1);
        waitDrain();
        chk("ovf_sticky", 16'(fifo_ovf), 16'd1);

        // Fill, then write on the same edge as a pop while full.
        doReset();
        chk("reset_clears_ovf", 16'(fifo_ovf), 16'd0);
        n = 0;
        while (m_q.size() < DEPTH && n < 20) begin
            applyStimulus(1'b1, 10'($urandom));
            n++;
        end
        if (n >= 20) timeoutFail("fill");
        n = 0;
        while (m_pos != 4 && n < 10) begin
            applyStimulus(1'b0, 10'h0);
            n++;
        end
        if (n >= 10) timeoutFail("phase4_wait");
        chk("full_before_pop", 16'(fifo_level), 16'd4);
        applyStimulus(1'b1, 10'h2C3);
        chk("full_pop_level", 16'(fifo_level), 16'd4);
        chk("full_pop_no_ovf", 16'(fifo_ovf), 16'd0);
        waitDrain();

        // Reset at phase 2 of a data word with two words still queued.
        applyStimulus(1'b1, 10'h0F3);
        applyStimulus(1'b1, 10'h30C);
        applyStimulus(1'b1, 10'h1E1);
        n = 0;
        while (!(m_pos == 2 && !m_cur_idle && m_q.size() == 2) && n < 20) begin
            applyStimulus(1'b0, 10'h0);
            n++;
        end
        if (n >= 20) timeoutFail("midword_wait");
        doReset();
        chk("midword_level", 16'(fifo_level), 16'd0);
        chk("midword_idle", 16'(idle_out), 16'd1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 10'h0);

        // Randomized traffic, including occasional overflow.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 99) < 22), 10'($urandom));
        end
        waitDrain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
